// File: rtl/usb_pkt_serializer.sv
// USB packet serializer: captures a handshake, token or data packet, then
// streams SYNC, PID, body and CRC one bit per cycle toward the bit-stuffer.
module usb_pkt_serializer #(
  parameter int unsigned MAX_BYTES = 8,
  parameter logic [7:0]  SYNC      = 8'b1000_0000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pkt_valid,
  output logic                           pkt_ready,
  input  logic [1:0]                     pkt_kind,
  input  logic [7:0]                     pid,
  input  logic [10:0]                    tok_field,
  input  logic [8*MAX_BYTES-1:0]         data,
  input  logic [$clog2(MAX_BYTES+1)-1:0] data_len,
  input  logic                           pause,
  input  logic                           sent_pkt,
  output logic                           start,
  output logic                           endr,
  output logic                           s_out,
  output logic                           pkt_done
);

  localparam int LW = $clog2(MAX_BYTES + 1);
  localparam int CW = $clog2(32 + 8 * MAX_BYTES + 1);
  localparam int DW = 8 * MAX_BYTES;

  localparam logic [1:0] KIND_HS   = 2'b00;
  localparam logic [1:0] KIND_TOK  = 2'b01;
  localparam logic [1:0] KIND_DATA = 2'b10;
  localparam logic [1:0] KIND_RSV  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_CRC,
    S_ENDW
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      kind_q, kind_d;
  logic [15:0]     hdr_q, hdr_d;     // {PID, SYNC}, shifted out LSB-first
  logic [10:0]     tok_q, tok_d;     // token body, shifted out LSB-first
  logic [DW-1:0]   data_q, data_d;   // payload, shifted out LSB-first
  logic [LW-1:0]   len_q, len_d;
  logic [15:0]     crc_q, crc_d;     // token CRC lives in bits [4:0]
  logic [CW-1:0]   cnt_q, cnt_d;     // bits consumed so far in this packet

  logic [LW-1:0]   len_clamped;
  logic [CW-1:0]   body_len;
  logic [CW-1:0]   body_end;
  logic [CW-1:0]   crc_end;
  logic            is_tok;
  logic            body_bit;
  logic            consume;
  logic            fb;

  // Packet geometry and the current body bit, derived from captured state.
  always_comb begin
    len_clamped = (data_len > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : data_len;
    is_tok      = (kind_q == KIND_TOK);
    case (kind_q)
      KIND_TOK:  body_len = CW'(11);
      KIND_DATA: body_len = CW'(len_q) << 3;
      default:   body_len = '0;
    endcase
    body_end = CW'(16) + body_len;
    crc_end  = body_end + (is_tok ? CW'(5) : CW'(16));
    body_bit = is_tok ? tok_q[0] : data_q[0];
    consume  = ((state_q == S_SHIFT) || (state_q == S_CRC)) && !pause;
    fb       = body_bit ^ (is_tok ? crc_q[4] : crc_q[15]);
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    hdr_d     = hdr_q;
    tok_d     = tok_q;
    data_d    = data_q;
    len_d     = len_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    pkt_ready = 1'b0;
    start     = 1'b0;
    endr      = 1'b0;
    s_out     = 1'b0;
    pkt_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        pkt_ready = 1'b1;
        if (pkt_valid && (pkt_kind != KIND_RSV)) begin
          kind_d  = pkt_kind;
          hdr_d   = {pid, SYNC};
          tok_d   = tok_field;
          data_d  = data;
          len_d   = len_clamped;
          crc_d   = 16'hFFFF;
          cnt_d   = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        start   = 1'b1;
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        s_out = (cnt_q < CW'(16)) ? hdr_q[0] : body_bit;
        if (consume) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q < CW'(16)) begin
            hdr_d = hdr_q >> 1;
          end else begin
            // Body bit: advance its shift register and the running CRC.
            if (is_tok) begin
              tok_d      = tok_q >> 1;
              crc_d[4:0] = {crc_q[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
            end else begin
              data_d = data_q >> 1;
              crc_d  = {crc_q[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
          end
          if (cnt_q == body_end - CW'(1)) begin
            if (kind_q == KIND_HS) begin
              endr    = 1'b1;
              state_d = S_ENDW;
            end else begin
              state_d = S_CRC;
            end
          end
        end
      end

      S_CRC: begin
        // The CRC is sent complemented, most significant bit first.
        s_out = is_tok ? ~crc_q[4] : ~crc_q[15];
        if (consume) begin
          cnt_d = cnt_q + CW'(1);
          crc_d = crc_q << 1;
          if (cnt_q == crc_end - CW'(1)) begin
            endr    = 1'b1;
            state_d = S_ENDW;
          end
        end
      end

      S_ENDW: begin
        if (sent_pkt) begin
          pkt_done = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          endr = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kind_q  <= '0;
      hdr_q   <= '0;
      tok_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      crc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      hdr_q   <= hdr_d;
      tok_q   <= tok_d;
      data_q  <= data_d;
      len_q   <= len_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_usb_pkt_serializer.sv
// Directed bench for usb_pkt_serializer: a reference model queues the expected
// wire bits per packet and the stream monitor pops one per consumed cycle.
module tb_usb_pkt_serializer;

  localparam int MB = 8;
  localparam int LW = $clog2(MB + 1);
  localparam int DW = 8 * MB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pkt_valid = 1'b0;
  logic [1:0]    pkt_kind = '0;
  logic [7:0]    pid = '0;
  logic [10:0]   tok_field = '0;
  logic [DW-1:0] data = '0;
  logic [LW-1:0] data_len = '0;
  logic          pause = 1'b0;
  logic          sent_pkt = 1'b0;
  logic          pkt_ready, start, endr, s_out, pkt_done;

  usb_pkt_serializer #(.MAX_BYTES(MB), .SYNC(8'b1000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_kind(pkt_kind), .pid(pid), .tok_field(tok_field), .data(data),
    .data_len(data_len), .pause(pause), .sent_pkt(sent_pkt), .start(start),
    .endr(endr), .s_out(s_out), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  bit           exp_q[$];
  logic [159:0] obs_bits;
  logic [159:0] ref_bits;
  int           obs_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected wire bits of one packet, in transmit order.
  task automatic push_pkt(input logic [1:0] k, input logic [7:0] p, input logic [10:0] tk,
                          input logic [DW-1:0] d, input logic [LW-1:0] ln);
    logic [7:0]  sy;
    logic [4:0]  c5;
    logic [15:0] c16;
    int          nb;
    bit          b;
    sy = 8'b1000_0000;
    for (int i = 0; i < 8; i++) exp_q.push_back(sy[i]);
    for (int i = 0; i < 8; i++) exp_q.push_back(p[i]);
    nb = (int'(ln) > MB) ? MB : int'(ln);
    if (k == 2'b01) begin
      c5 = 5'h1F;
      for (int i = 0; i < 11; i++) begin
        b = tk[i];
        exp_q.push_back(b);
        if (b ^ c5[4]) c5 = (c5 << 1) ^ 5'h05;
        else           c5 = c5 << 1;
      end
      for (int i = 4; i >= 0; i--) exp_q.push_back(~c5[i]);
    end else if (k == 2'b10) begin
      c16 = 16'hFFFF;
      for (int i = 0; i < nb * 8; i++) begin
        b = d[i];
        exp_q.push_back(b);
        if (b ^ c16[15]) c16 = (c16 << 1) ^ 16'h8005;
        else             c16 = c16 << 1;
      end
      for (int i = 15; i >= 0; i--) exp_q.push_back(~c16[i]);
    end
  endtask

  // One packet: offer at the current (post-negedge) instant, monitor the
  // stream, then complete ENDW with sent_pkt in cycle sent_after after endr.
  task automatic xfer(input logic [1:0] k, input logic [7:0] p, input logic [10:0] tk,
                      input logic [DW-1:0] d, input logic [LW-1:0] ln, input bit use_pause,
                      input int sent_after, input bit noise, input int abort_bit);
    int   n;
    int   cyc;
    int   paused;
    bit   prev_p;
    logic prev_s;
    bit   done;
    logic got;
    cyc = 0; paused = 0; prev_p = 1'b0; prev_s = 1'b0; done = 1'b0;
    exp_q.delete();
    push_pkt(k, p, tk, d, ln);
    n = exp_q.size();
    obs_n = 0;
    obs_bits = '0;
    pkt_valid = 1'b1; pkt_kind = k; pid = p; tok_field = tk; data = d; data_len = ln;
    #1 chk("ready_before_accept", 32'(pkt_ready), 32'd1);
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
    pkt_kind = 2'($urandom); pid = 8'($urandom); tok_field = 11'($urandom);
    data = {$urandom, $urandom}; data_len = LW'($urandom);
    @(negedge clk);
    pause = use_pause ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    chk("start_pulse", 32'(start), 32'd1);
    chk("ready_busy", 32'(pkt_ready), 32'd0);
    for (int guard = 0; guard < 4 * n + 64; guard++) begin
      @(negedge clk);
      pause = use_pause ? ($urandom_range(0, 2) == 0) : 1'b0;
      sent_pkt = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      cyc++;
      if (cyc == 1) chk("start_one_cycle", 32'(start), 32'd0);
      if (prev_p) chk("hold_while_paused", 32'(s_out), 32'(prev_s));
      if (noise) chk("no_done_midstream", 32'(pkt_done), 32'd0);
      if (abort_bit >= 0 && obs_n == abort_bit) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(pkt_ready), 32'd1);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_endr", 32'(endr), 32'd0);
        chk("rst_s_out", 32'(s_out), 32'd0);
        chk("rst_done", 32'(pkt_done), 32'd0);
        pause = 1'b0; sent_pkt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          sent_pkt = (i == 1);
          #1;
          chk("abort_no_done", 32'(pkt_done), 32'd0);
          chk("abort_no_endr", 32'(endr), 32'd0);
          chk("abort_idle", 32'(pkt_ready), 32'd1);
        end
        sent_pkt = 1'b0;
        exp_q.delete();
        return;
      end
      prev_p = pause;
      prev_s = s_out;
      if (pause) begin
        paused++;
      end else begin
        if (exp_q.size() == 0) begin
          chk("extra_bit", 32'(obs_n + 1), 32'(n));
          break;
        end
        got = s_out;
        obs_bits[obs_n] = got;
        obs_n++;
        chk($sformatf("bit%0d", obs_n - 1), 32'(got), 32'(exp_q.pop_front()));
        if (endr) begin
          done = 1'b1;
          break;
        end
      end
    end
    pause = 1'b0;
    sent_pkt = 1'b0;
    if (!done) begin
      chk("endr_timeout", 32'(endr), 32'd1);
      return;
    end
    chk("bits_left", 32'(exp_q.size()), 32'd0);
    chk("stream_cycles", 32'(cyc), 32'(n + paused));
    for (int i = 1; i < sent_after; i++) begin
      @(negedge clk);
      pause = 1'($urandom_range(0, 1));
      #1;
      chk("endr_held", 32'(endr), 32'd1);
      chk("no_early_done", 32'(pkt_done), 32'd0);
    end
    @(negedge clk);
    pause = 1'b0;
    sent_pkt = 1'b1;
    #1;
    chk("pkt_done", 32'(pkt_done), 32'd1);
    chk("endr_drop", 32'(endr), 32'd0);
    @(negedge clk);
    sent_pkt = 1'b0;
    #1;
    chk("ready_after_done", 32'(pkt_ready), 32'd1);
    chk("done_one_cycle", 32'(pkt_done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] pay;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", 32'(pkt_ready), 32'd1);
    chk("reset_start", 32'(start), 32'd0);
    chk("reset_endr", 32'(endr), 32'd0);
    chk("reset_s_out", 32'(s_out), 32'd0);
    chk("reset_done", 32'(pkt_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // ACK handshake, sent_pkt three cycles after endr.
    xfer(2'b00, 8'hD2, '0, '0, '0, 1'b0, 3, 1'b0, -1);
    chk("ack_wire", 32'(obs_bits[15:0]), 32'h0000_D280);
    chk("ack_len", 32'(obs_n), 32'd16);

    // SETUP token to address 0, endpoint 0.
    xfer(2'b01, 8'h2D, 11'h000, '0, '0, 1'b0, 1, 1'b0, -1);
    chk("setup_crc5", 32'(obs_bits[31:27]), 32'b00010);
    chk("setup_len", 32'(obs_n), 32'd32);

    // Zero-length DATA0.
    xfer(2'b10, 8'hC3, '0, {$urandom, $urandom}, '0, 1'b0, 2, 1'b0, -1);
    chk("zlp_crc16", 32'(obs_bits[31:16]), 32'h0);
    chk("zlp_len", 32'(obs_n), 32'd32);

    // Oversized length clamps to MB bytes.
    xfer(2'b10, 8'hC3, '0, {$urandom, $urandom}, LW'(MB + 3), 1'b0, 1, 1'b0, -1);
    chk("clamp_len", 32'(obs_n), 32'(32 + 8 * MB));

    // Full payload unpaused, then the same payload under random pause.
    pay = {$urandom, $urandom};
    xfer(2'b10, 8'h4B, '0, pay, LW'(MB), 1'b0, 2, 1'b0, -1);
    ref_bits = obs_bits;
    xfer(2'b10, 8'h4B, '0, pay, LW'(MB), 1'b1, 4, 1'b0, -1);
    for (int s = 0; s < 3; s++)
      chk($sformatf("pause_same_w%0d", s), obs_bits[32*s +: 32], ref_bits[32*s +: 32]);

    // Random token with sent_pkt toggling during the stream.
    xfer(2'b01, 8'hE1, 11'($urandom), '0, '0, 1'b1, 2, 1'b1, -1);

    // Reserved kind is never accepted.
    pkt_valid = 1'b1;
    pkt_kind = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("rsv_ready", 32'(pkt_ready), 32'd1);
      chk("rsv_no_start", 32'(start), 32'd0);
    end
    pkt_valid = 1'b0;

    // Two handshakes back-to-back.
    xfer(2'b00, 8'hD2, '0, '0, '0, 1'b0, 1, 1'b0, -1);
    xfer(2'b00, 8'h5A, '0, '0, '0, 1'b0, 1, 1'b0, -1);

    // Reset at bit 10 of a token, then a clean token.
    xfer(2'b01, 8'h69, 11'($urandom), '0, '0, 1'b0, 1, 1'b0, 10);
    xfer(2'b01, 8'h69, 11'($urandom), '0, '0, 1'b0, 2, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_pkt_serializer.md
# usb_pkt_serializer

Parametrised USB packet serializer. It sits between the protocol FSM and the bit-stuffer/NRZI stage. It accepts handshake, token and variable-length data packets over a valid/ready handshake, prepends SYNC and PID, and generates and appends CRC5 (tokens) or CRC16 (data). It streams the result one bit per cycle under back-pressure from the bit-stuffer and reports completion once the line driver confirms transmission.

## Interface
Parameters:
- MAX_BYTES, 8: maximum data-packet payload in bytes (1..64).
- SYNC, 8'b1000_0000: sync pattern, sent LSB-first (wire sees 0000_0001).

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pkt_valid  in  1  request present
- pkt_ready  out  1  serializer idle, can accept
- pkt_kind  in  2  00 handshake, 01 token, 10 data, 11 reserved
- pid  in  8  PID byte, including check nibble
- tok_field  in  11  token ADDR[6:0] + ENDP[3:0] (addr in bits 6:0)
- data  in  8*MAX_BYTES  payload; byte i = data[8i+7:8i]; byte 0 sent first
- data_len  in  $clog2(MAX_BYTES+1)  payload byte count, 0..MAX_BYTES
- pause  in  1  bit-stuffer stall; current bit not consumed
- sent_pkt  in  1  line driver finished EOP
- start  out  1  one-cycle pulse, packet stream begins
- endr  out  1  end of stream, held until sent_pkt
- s_out  out  1  serial bit, valid in SHIFT state
- pkt_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, START, SHIFT, CRC, ENDW.
- **IDLE**
  - pkt_ready=1.
  - pkt_valid && pkt_kind!=11 accepts: pid, tok_field, data and clamp(data_len, MAX_BYTES) are captured into internal registers, CRC register is initialised, go to START.
  - pkt_kind==11 is never accepted; stay IDLE.
- **START**
  - start=1 for one cycle, then SHIFT.
- **SHIFT**
  - s_out = current bit of SYNC, PID, then body, each field LSB-first.
  - Bit consumed on any SHIFT/CRC cycle with pause=0; pause=1 holds s_out and all counters.
  - Body: handshake has none; token is tok_field[0]..[10]; data is bytes 0..len-1.
  - CRC updates only on consumed body bits.
  - Go to CRC after the last body bit is consumed. A handshake goes to ENDW after the last PID bit.
- **CRC**
  - Token: CRC5, poly x^5+x^2+1, init 5'h1F, complemented, bit4 first.
  - Data: CRC16, poly 0x8005, init 16'hFFFF, complemented, bit15 first.
  - Same pause rule as SHIFT. Go to ENDW after the last CRC bit.
- **ENDW**
  - endr=1 from the cycle the last bit is consumed (Mealy) and held while waiting.
  - sent_pkt=1: endr=0, pkt_done=1, go to IDLE.
- Lengths: handshake 16 bits, token 32, data 32+8*len (zero-length data = 32).
- Bit counter width is $clog2(32+8*MAX_BYTES+1); it never wraps.
- sent_pkt outside ENDW is ignored.
- Inputs other than pause and sent_pkt are don't-care after acceptance.

## Timing
- Reset (and mid-packet reset): state IDLE, pkt_ready=1, start=0, endr=0, s_out=0, pkt_done=0, counters and CRC cleared.
  - Aborted packet gets no endr or pkt_done.
- Accept at edge T; start=1 in cycle T+1; first SYNC bit on s_out in T+2.
- With pause=0 the last bit is on s_out in cycle T+1+N, where N is packet bits.
  - endr rises in that same cycle.
- pkt_done is asserted in the cycle sent_pkt is sampled high in ENDW.
  - pkt_ready=1 the following cycle.
  - Minimum back-to-back gap: one IDLE cycle.
- pause asserted in START has no effect; start still lasts one cycle.
- pause in ENDW is ignored.

## Test plan
- **Handshake ACK** (pid 8'hD2), no pause:
  - s_out = 0,0,0,0,0,0,0,1,0,1,0,0,1,0,1,1 over 16 cycles.
  - endr on the 16th bit; sent_pkt 3 cycles later gives pkt_done, then pkt_ready.
- **SETUP token** (pid 8'h2D, tok_field 0):
  - 32 bits; after 11 zero body bits, CRC5 bits on wire = 0,1,0,0,0.
- **Zero-length DATA0** (pid 8'hC3, data_len 0):
  - 32 bits; final 16 CRC bits all 0.
  - data_len = MAX_BYTES+3 behaves as MAX_BYTES.
- **Pause mid-stream**: random pause on a data packet with MAX_BYTES bytes.
  - Bit sequence identical to the unpaused run; s_out stable while pause=1.
  - Total cycles = bits + paused cycles.
- **Reserved and back-to-back**:
  - pkt_kind=11 held 10 cycles: no start, pkt_ready stays 1.
  - Then two handshakes back-to-back: second accepted exactly one cycle after the first pkt_done.
- **Mid-packet reset**: rst_n low at bit 10 of a token.
  - All outputs reach reset values immediately; no pkt_done.
  - Next packet serializes correctly.
